// File: rtl/xtal_clock_qualifier.sv
// Crystal clock qualifier: IDLE -> WARMUP -> RUN sequencing, divided clock, tick strobe, phase check.
// Optional saturating RUN-cycle counter is built only when XTAL_CYCLE_COUNTER_EN is defined.
module xtal_clock_qualifier #(
    parameter int WARMUP_CYCLES = 1024,
    parameter int DIVIDE        = 8,
    parameter int COUNT_WIDTH   = 16
) (
    input  logic                   Clock,
    input  logic                   ResetN,
    input  logic                   ClockN,
    input  logic                   Enable,
    output logic                   ClockGood,
    output logic                   Tick,
    output logic                   DivClock,
    output logic                   PhaseError,
    output logic [1:0]             State,
    output logic [COUNT_WIDTH-1:0] CycleCount
);
    localparam int WW = (WARMUP_CYCLES > 1) ? $clog2(WARMUP_CYCLES) : 1;
    localparam int DW = $clog2(DIVIDE);
    localparam logic [WW-1:0] W_LAST = WW'(WARMUP_CYCLES - 1);
    localparam logic [DW-1:0] D_LAST = DW'(DIVIDE - 1);
    localparam logic [DW-1:0] D_HALF = DW'(DIVIDE / 2 - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        WARMUP = 2'b01,
        RUN    = 2'b10
    } state_t;

    state_t        state;
    logic [WW-1:0] warm_cnt;
    logic [DW-1:0] div_cnt;
    logic          div_clk;
    logic          phase_err;
    logic          clockn_p0;
    logic          clockn_p1;

    // ClockN is only data here; two flops keep its sampling off the oscillator's phase relationship.
    always_ff @(posedge Clock) begin
        clockn_p0 <= ClockN;
        clockn_p1 <= clockn_p0;
    end

    always_ff @(posedge Clock) begin
        if (!ResetN) begin
            state     <= IDLE;
            warm_cnt  <= '0;
            div_cnt   <= '0;
            div_clk   <= 1'b0;
            phase_err <= 1'b0;
        end else if (!Enable) begin
            state    <= IDLE;
            warm_cnt <= '0;
            div_cnt  <= '0;
            div_clk  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state    <= WARMUP;
                    warm_cnt <= '0;
                end
                WARMUP: begin
                    warm_cnt <= warm_cnt + 1'b1;
                    if (warm_cnt == W_LAST) begin
                        state   <= RUN;
                        div_cnt <= '0;
                        div_clk <= 1'b0;
                    end
                end
                RUN: begin
                    div_cnt <= (div_cnt == D_LAST) ? '0 : div_cnt + 1'b1;
                    if (div_cnt == D_HALF || div_cnt == D_LAST)
                        div_clk <= ~div_clk;
                    if (clockn_p1)
                        phase_err <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef XTAL_CYCLE_COUNTER_EN
    logic [COUNT_WIDTH-1:0] cycle_cnt;

    // Counts only edges that begin in RUN and stay there; holds at all-ones instead of wrapping.
    always_ff @(posedge Clock) begin
        if (!ResetN)
            cycle_cnt <= '0;
        else if (Enable && state == RUN && cycle_cnt != '1)
            cycle_cnt <= cycle_cnt + 1'b1;
    end

    assign CycleCount = cycle_cnt;
`else
    assign CycleCount = '0;
`endif

    assign State      = state;
    assign ClockGood  = (state == RUN);
    assign Tick       = (state == RUN) && (div_cnt == D_LAST);
    assign DivClock   = div_clk;
    assign PhaseError = phase_err;
endmodule
